// File: rtl/dcache_sa_pkg.sv
// Shared definitions for the set-associative data cache controller.
// Holds the controller state enum and the width-derivation helpers that
// turn the cache geometry parameters into address-field and way widths.
package dcache_sa_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_e;

  // Byte-offset bits inside one cache line.
  function automatic int off_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Set-index bits.
  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits: whatever remains above offset and index.
  function automatic int tag_bits(input int addr_w, input int line_w, input int sets);
    return addr_w - off_bits(line_w) - idx_bits(sets);
  endfunction

  // CPU words per cache line.
  function automatic int words_per_line(input int line_w, input int data_w);
    return line_w / data_w;
  endfunction

  // Width of an LRU age (also of a way number); at least one bit.
  function automatic int age_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_sa_tag_array.sv
// Tag/valid/dirty/LRU store for the set-associative data cache.
// Lookup (hit detection, victim selection, tag read-back) is combinational
// on the presented index; all updates happen at the clock edge.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   index_i, tag_i      lookup set and tag
//   hit_o, hit_way_o    hit flag and the way that hit
//   victim_way_o        replacement way for a miss in index_i
//   victim_dirty_o      that way holds a modified line
//   rd_way_i, rd_tag_o  tag read-back of one way (write-back address)
//   touch_en_i          hit access: touch_way_i becomes MRU
//   set_dirty_i         with touch_en_i, mark touch_way_i dirty
//   fill_en_i           refill: fill_way_i gets tag_i, valid, clean, MRU
module dcache_sa_tag_array
  import dcache_sa_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int TAG_W = 23,
  parameter int IDX_W = 4,
  parameter int WAY_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] index_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             hit_o,
  output logic [WAY_W-1:0] hit_way_o,
  output logic [WAY_W-1:0] victim_way_o,
  output logic             victim_dirty_o,
  input  logic [WAY_W-1:0] rd_way_i,
  output logic [TAG_W-1:0] rd_tag_o,
  input  logic             touch_en_i,
  input  logic             set_dirty_i,
  input  logic [WAY_W-1:0] touch_way_i,
  input  logic             fill_en_i,
  input  logic [WAY_W-1:0] fill_way_i
);

  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [TAG_W-1:0] tag_d   [SETS][WAYS];
  logic             valid_q [SETS][WAYS];
  logic             valid_d [SETS][WAYS];
  logic             dirty_q [SETS][WAYS];
  logic             dirty_d [SETS][WAYS];
  logic [WAY_W-1:0] age_q   [SETS][WAYS];
  logic [WAY_W-1:0] age_d   [SETS][WAYS];

  logic             victim_found;
  logic [WAY_W-1:0] upd_way;
  logic [WAY_W-1:0] upd_age;

  always_comb begin
    hit_o     = 1'b0;
    hit_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_o && valid_q[index_i][w] && (tag_q[index_i][w] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
    end
  end

  // Ages of a set are always a permutation of 0..WAYS-1, so once every way
  // is valid the LRU way is simply the one whose age is WAYS-1.
  always_comb begin
    victim_found = 1'b0;
    victim_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[index_i][w]) begin
        victim_found = 1'b1;
        victim_way_o = WAY_W'(w);
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[index_i][w] == WAY_W'(WAYS - 1)) begin
          victim_way_o = WAY_W'(w);
        end
      end
    end
    victim_dirty_o = valid_q[index_i][victim_way_o] && dirty_q[index_i][victim_way_o];
    rd_tag_o       = tag_q[index_i][rd_way_i];
  end

  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    age_d   = age_q;
    upd_way = fill_en_i ? fill_way_i : touch_way_i;
    upd_age = age_q[index_i][upd_way];
    // The accessed way becomes MRU; only ways more recent than it age.
    if (touch_en_i || fill_en_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way) begin
          age_d[index_i][w] = '0;
        end else if (age_q[index_i][w] < upd_age) begin
          age_d[index_i][w] = age_q[index_i][w] + 1'b1;
        end
      end
    end
    if (touch_en_i && set_dirty_i) begin
      dirty_d[index_i][touch_way_i] = 1'b1;
    end
    if (fill_en_i) begin
      tag_d[index_i][fill_way_i]   = tag_i;
      valid_d[index_i][fill_way_i] = 1'b1;
      dirty_d[index_i][fill_way_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]   <= '0;
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: rtl/dcache_sa_ctrl.sv
// Set-associative, write-back, write-allocate data cache controller with
// true-LRU replacement. Hits complete in the presenting cycle; a miss stalls
// the CPU, optionally writes back a dirty victim, refills the line from
// memory and then replays the request as a hit.
// Optional build macro DCACHE_SA_STATS_EN adds hit/miss counters.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   p1_data_i, p1_addr_i           CPU store data, word-aligned byte address
//   p1_MemRead_i, p1_MemWrite_i    load / store strobes (both high = store)
//   p1_data_o, p1_stall_o          load data, request not yet complete
//   mem_data_i, mem_ack_i          refill line, memory transaction done
//   mem_data_o, mem_addr_o         write-back line, line-aligned address
//   mem_enable_o, mem_write_o      memory request level, 1 = write-back
//   hit_cnt_o, miss_cnt_o          (DCACHE_SA_STATS_EN only) access counters
module dcache_sa_ctrl
  import dcache_sa_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
`ifdef DCACHE_SA_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W  = off_bits(LINE_W);
  localparam int IDX_W  = idx_bits(SETS);
  localparam int TAG_W  = tag_bits(ADDR_W, LINE_W, SETS);
  localparam int WORDS  = words_per_line(LINE_W, DATA_W);
  localparam int WSEL_W = $clog2(WORDS);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WAY_W  = age_bits(WAYS);

  logic              req;
  logic              is_store;
  logic              is_load;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic              unused_byte_bits;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim_way;
  logic              victim_dirty;
  logic [TAG_W-1:0]  victim_tag;
  logic              touch_en;
  logic              fill_en;

  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;

  logic [LINE_W-1:0] data_q [SETS][WAYS];
  logic [LINE_W-1:0] data_d [SETS][WAYS];
  logic [LINE_W-1:0] hit_line;
  logic [LINE_W-1:0] victim_line;
  logic [LINE_W-1:0] st_line;

  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign is_store         = p1_MemWrite_i;
  assign is_load          = p1_MemRead_i & ~p1_MemWrite_i;
  assign index            = p1_addr_i[OFF_W +: IDX_W];
  assign tag              = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel             = p1_addr_i[BYTE_W +: WSEL_W];
  assign unused_byte_bits = ^p1_addr_i[BYTE_W-1:0];

  assign touch_en = (state_q == IDLE) && req && hit;
  assign fill_en  = (state_q == REFILL) && mem_ack_i;

  dcache_sa_tag_array #(
    .SETS  (SETS),
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_tag_array (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .index_i        (index),
    .tag_i          (tag),
    .hit_o          (hit),
    .hit_way_o      (hit_way),
    .victim_way_o   (victim_way),
    .victim_dirty_o (victim_dirty),
    .rd_way_i       (victim_q),
    .rd_tag_o       (victim_tag),
    .touch_en_i     (touch_en),
    .set_dirty_i    (is_store),
    .touch_way_i    (hit_way),
    .fill_en_i      (fill_en),
    .fill_way_i     (victim_q)
  );

  always_comb begin
    hit_line    = data_q[index][hit_way];
    victim_line = data_q[index][victim_q];
    st_line     = hit_line;
    st_line[wsel*DATA_W +: DATA_W] = p1_data_i;
    data_d = data_q;
    if (touch_en && is_store) begin
      data_d[index][hit_way] = st_line;
    end
    if (fill_en) begin
      data_d[index][victim_q] = mem_data_i;
    end
  end

  // Line data carries no reset; valid bits in the tag array guard it.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    p1_stall_o   = 1'b0;
    p1_data_o    = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (is_load) begin
              p1_data_o = hit_line[wsel*DATA_W +: DATA_W];
            end
          end else begin
            p1_stall_o = 1'b1;
            victim_d   = victim_way;
            state_d    = victim_dirty ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {victim_tag, index, {OFF_W{1'b0}}};
        mem_data_o   = victim_line;
        if (mem_ack_i) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {p1_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef DCACHE_SA_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        replay_q, replay_d;

  // The hit that follows a refill is the replay of an already-counted miss.
  always_comb begin
    replay_d   = fill_en;
    hit_cnt_d  = hit_cnt_q + 32'(touch_en && !replay_q);
    miss_cnt_d = miss_cnt_q + 32'((state_q == IDLE) && req && !hit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      replay_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      replay_q   <= replay_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_sa_ctrl.sv
// Scoreboard bench for dcache_sa_ctrl (default geometry: 2 ways, 16 sets,
// 256-bit lines). A recency-list cache model predicts each access; the CPU
// and memory monitors pop and compare predictions as the DUT completes them.
module tb_dcache_sa_ctrl;

  localparam int WAYS = 2;
  localparam int SETS = 16;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_addr_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
`ifdef DCACHE_SA_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  always #5 clk = ~clk;

  dcache_sa_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .p1_data_i     (p1_data_i),
    .p1_addr_i     (p1_addr_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o)
`ifdef DCACHE_SA_STATS_EN
    ,
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
`endif
  );

  typedef struct {
    bit          hit;
    bit          is_load;
    logic [31:0] data;
  } cpu_exp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_exp_t;

  int errors = 0;
  int checks = 0;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  // Reference model: per set, resident line addresses ordered MRU first.
  int           set_q [SETS][$];
  logic [255:0] cache_data [int];
  bit           cache_dirty [int];
  logic [255:0] ref_mem [int];
  int           model_hits = 0;
  int           model_misses = 0;

  // Memory responder's own storage.
  logic [255:0] mem_store [int];

  bit resp_en = 1'b0;
  bit mon_en = 1'b0;
  int stray_req = 0;
  int stray_done = 0;
  int done_cnt = 0;
  int wait_cyc = 0;
  cpu_exp_t mon_ce;
  mem_exp_t mon_me;

  function automatic logic [255:0] init_line(input int line);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) begin
      l[k*32 +: 32] = (32'(line) * 32'h9E37_79B1) ^ (32'(k) * 32'h85EB_CA6B) ^ 32'h5A5A_0000;
    end
    return l;
  endfunction

  function automatic logic [255:0] ref_read(input int line);
    if (ref_mem.exists(line)) return ref_mem[line];
    return init_line(line);
  endfunction

  function automatic logic [255:0] store_read(input int line);
    if (mem_store.exists(line)) return mem_store[line];
    return init_line(line);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) set_q[s].delete();
    cache_data.delete();
    cache_dirty.delete();
  endtask

  task automatic model_access(input logic [31:0] addr, input bit st, input logic [31:0] wdata,
                              output bit hit, output logic [31:0] rdata);
    int line;
    int s;
    int w;
    int pos;
    int v;
    logic [255:0] tmp;
    line = int'(addr & 32'hFFFF_FFE0);
    s    = int'((addr >> 5) & 32'hF);
    w    = int'((addr >> 2) & 32'h7);
    pos  = -1;
    for (int i = 0; i < set_q[s].size(); i++) if (set_q[s][i] == line) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      set_q[s].delete(pos);
    end else begin
      hit = 1'b0;
      if (set_q[s].size() == WAYS) begin
        v = set_q[s].pop_back();
        if (cache_dirty[v]) begin
          mem_q.push_back('{wr: 1'b1, addr: 32'(v), data: cache_data[v]});
          ref_mem[v] = cache_data[v];
        end
        cache_data.delete(v);
        cache_dirty.delete(v);
      end
      mem_q.push_back('{wr: 1'b0, addr: 32'(line), data: '0});
      cache_data[line]  = ref_read(line);
      cache_dirty[line] = 1'b0;
    end
    set_q[s].push_front(line);
    tmp = cache_data[line];
    if (st) begin
      tmp[w*32 +: 32]   = wdata;
      cache_data[line]  = tmp;
      cache_dirty[line] = 1'b1;
      rdata = '0;
    end else begin
      rdata = tmp[w*32 +: 32];
    end
  endtask

  task automatic access(input logic [31:0] addr, input bit rd, input bit wr, input logic [31:0] wdata);
    bit hit;
    logic [31:0] rdata;
    int start;
    bit ok;
    model_access(addr, wr, wdata, hit, rdata);
    if (hit) model_hits++; else model_misses++;
    cpu_q.push_back('{hit: hit, is_load: rd && !wr, data: rdata});
    @(posedge clk);
    #1;
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    start = done_cnt;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    p1_data_i     = $urandom;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr %h never completed, required completion within 400 cycles", addr);
      cpu_q.delete();
      mem_q.delete();
    end
  endtask

  // CPU-side and memory-side monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      if (p1_MemRead_i || p1_MemWrite_i) begin
        if (!p1_stall_o) begin
          checks++;
          if (cpu_q.size() == 0) begin
            errors++;
            $display("FAIL cpu_unexpected: completion at addr %h with nothing expected", p1_addr_i);
          end else begin
            mon_ce = cpu_q.pop_front();
            if ((wait_cyc == 0) != mon_ce.hit) begin
              errors++;
              $display("FAIL hit_class: addr %h stalled %0d cycles, expected hit=%0d", p1_addr_i, wait_cyc, mon_ce.hit);
            end
            if (mon_ce.is_load) begin
              checks++;
              if (p1_data_o !== mon_ce.data) begin
                errors++;
                $display("FAIL load_data: addr %h got %h expected %h", p1_addr_i, p1_data_o, mon_ce.data);
              end
            end
          end
          wait_cyc = 0;
          done_cnt++;
        end else begin
          wait_cyc++;
        end
      end else begin
        checks++;
        if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) begin
          errors++;
          $display("FAIL idle_outputs: stall=%b data=%h expected 0/0", p1_stall_o, p1_data_o);
        end
      end
      if (mem_enable_o && mem_ack_i) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: write=%b addr %h with nothing expected", mem_write_o, mem_addr_o);
        end else begin
          mon_me = mem_q.pop_front();
          if (mem_write_o !== mon_me.wr || mem_addr_o !== mon_me.addr) begin
            errors++;
            $display("FAIL mem_txn: write=%b addr %h expected write=%b addr %h",
                     mem_write_o, mem_addr_o, mon_me.wr, mon_me.addr);
          end else if (mon_me.wr) begin
            checks++;
            if (mem_data_o !== mon_me.data) begin
              errors++;
              $display("FAIL wb_data: addr %h got %h expected %h", mem_addr_o, mem_data_o, mon_me.data);
            end
          end
        end
      end
    end
  end

  // Memory responder: acks after a random delay, or issues a stray ack on request.
  initial begin
    int d;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (stray_req != stray_done) begin
        mem_data_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mem_ack_i  = 1'b1;
        @(posedge clk);
        #2;
        mem_ack_i = 1'b0;
        stray_done++;
      end else if (resp_en && mem_enable_o) begin
        d = $urandom_range(0, 4);
        for (int i = 0; i < d; i++) begin
          @(posedge clk);
          #2;
        end
        if (mem_write_o) mem_store[int'(mem_addr_o)] = mem_data_o;
        else mem_data_i = store_read(int'(mem_addr_o));
        mem_ack_i = 1'b1;
        @(posedge clk);
        #2;
        mem_ack_i = 1'b0;
      end
    end
  end

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    int           op;
    bit           ok;
    rst_i         = 1'b1;
    p1_data_i     = '0;
    p1_addr_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;

    l = init_line(32'h40);
    l[63:32] = 32'h1111_2222;
    ref_mem[32'h40]   = l;
    mem_store[32'h40] = l;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_stall", p1_stall_o, 0);
    chk("rst_p1_data", p1_data_o, 0);
    chk("rst_mem_enable", mem_enable_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
`ifdef DCACHE_SA_STATS_EN
    chk("rst_hit_cnt", hit_cnt_o, 0);
    chk("rst_miss_cnt", miss_cnt_o, 0);
`endif

    // Miss, then reset while the refill is outstanding.
    @(posedge clk);
    #1;
    p1_addr_i    = 32'h44;
    p1_MemRead_i = 1'b1;
    @(negedge clk);
    chk("miss_stall", p1_stall_o, 1);
    @(negedge clk);
    chk("refill_enable", mem_enable_o, 1);
    chk("refill_write", mem_write_o, 0);
    chk("refill_addr", mem_addr_o, 32'h40);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i        = 1'b0;
    p1_MemRead_i = 1'b0;
    @(negedge clk);
    chk("abort_enable", mem_enable_o, 0);
    chk("abort_stall", p1_stall_o, 0);
    stray_req++;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      if (stray_done == stray_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("stray_ack_issued", ok, 1);
    @(negedge clk);
    chk("late_ack_enable", mem_enable_o, 0);
    chk("late_ack_stall", p1_stall_o, 0);

    model_reset();
    resp_en = 1'b1;
    mon_en  = 1'b1;

    access(32'h44, 1, 0, 0);
    access(32'h44, 1, 0, 0);
`ifdef DCACHE_SA_STATS_EN
    @(negedge clk);
    chk("stats_hit_1", hit_cnt_o, 1);
    chk("stats_miss_1", miss_cnt_o, 1);
`endif
    access(32'h40, 0, 1, 32'hDEAD_BEEF);
    access(32'h240, 1, 0, 0);
    access(32'h440, 1, 0, 0);
    access(32'h240, 1, 0, 0);
    access(32'h640, 1, 0, 0);
    access(32'h40, 1, 1, 32'hCAFE_F00D);
    access(32'h40, 1, 0, 0);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 5) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      if (op <= 3) access(a, 1, 0, 0);
      else if (op <= 6) access(a, 0, 1, $urandom);
      else if (op == 7) access(a, 1, 1, $urandom);
      else repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cpu_queue_drained", cpu_q.size(), 0);
    chk("mem_queue_drained", mem_q.size(), 0);
`ifdef DCACHE_SA_STATS_EN
    chk("stats_hit_final", hit_cnt_o, model_hits);
    chk("stats_miss_final", miss_cnt_o, model_misses);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
